// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD message arbiter.
// Holds the arbiter state encoding, the LCD row width and the idle banner text.
package lcd_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    localparam int ROW_W     = 160;
    localparam int ROW_CHARS = 20;

    // Builds a full row of ASCII spaces, one byte per character position.
    function automatic logic [ROW_W-1:0] space_fill();
        logic [ROW_W-1:0] row;
        row = {ROW_W{1'b0}};
        for (int i = 0; i < ROW_CHARS; i++) begin
            row[i*8 +: 8] = 8'h20;
        end
        return row;
    endfunction

    localparam logic [ROW_W-1:0] SPACE_ROW = space_fill();

endpackage

// File: rtl/lcd_rr_pick.sv
// Rotating-priority picker: urgent requesters win over plain ones, and ties
// are broken in rotated order starting just after the last-granted pointer.
module lcd_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] urgent_i,
    input  logic [IW-1:0]    ptr_i,
    output logic             valid_o,
    output logic [N_REQ-1:0] pick_o,
    output logic [IW-1:0]    idx_o
);

    logic [N_REQ-1:0] cand_s;

    // Narrow the candidate set to urgent requesters whenever any exist.
    assign cand_s = (|(req_i & urgent_i)) ? (req_i & urgent_i) : req_i;

    // Scan candidates from ptr+1 around to ptr and keep the first hit.
    always_comb begin
        logic [IW-1:0] j;
        valid_o = 1'b0;
        pick_o  = {N_REQ{1'b0}};
        idx_o   = {IW{1'b0}};
        j       = {IW{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            j = IW'((int'(ptr_i) + k) % N_REQ);
            if (!valid_o && cand_s[j]) begin
                valid_o   = 1'b1;
                idx_o     = j;
                pick_o[j] = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Time-shares a 2x20 character LCD between N_REQ requesters with a minimum
// and maximum display time, urgent preemption and an idle banner.
module lcd_msg_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int                N_REQ       = 4,
    parameter int                ROW_W       = lcd_arb_pkg::ROW_W,
    parameter int                HOLD_CYCLES = 50_000_000,
    parameter int                MIN_CYCLES  = 5_000_000,
    parameter logic [ROW_W-1:0]  DEF_ROW1    = ROW_W'(lcd_arb_pkg::SPACE_ROW),
    parameter logic [ROW_W-1:0]  DEF_ROW2    = ROW_W'(lcd_arb_pkg::SPACE_ROW)
) (
    input  logic                   CLK,
    input  logic                   _RST,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       urgent,
    input  logic [N_REQ*ROW_W-1:0] req_row1,
    input  logic [N_REQ*ROW_W-1:0] req_row2,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [ROW_W-1:0]       row_1,
    output logic [ROW_W-1:0]       row_2
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MIN  = CW'(MIN_CYCLES - 1);

    if (MIN_CYCLES > HOLD_CYCLES) begin : g_cfg_check
        $error("lcd_msg_arbiter: MIN_CYCLES must not exceed HOLD_CYCLES");
    end

    state_e           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] done_q;
    logic [IW-1:0]    gidx_q;
    logic [IW-1:0]    ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [ROW_W-1:0] row1_q;
    logic [ROW_W-1:0] row2_q;

    logic [ROW_W-1:0] row1_arr_s [N_REQ];
    logic [ROW_W-1:0] row2_arr_s [N_REQ];
    logic             pick_valid_s;
    logic [N_REQ-1:0] pick_oh_s;
    logic [IW-1:0]    pick_idx_s;
    logic [IW-1:0]    pick_ptr_s;
    logic             min_ok_s;
    logic             others_urgent_s;
    logic             release_s;

    for (genvar i = 0; i < N_REQ; i++) begin : g_rows
        assign row1_arr_s[i] = req_row1[i*ROW_W +: ROW_W];
        assign row2_arr_s[i] = req_row2[i*ROW_W +: ROW_W];
    end

    // While showing, rank from the granted index so a handover places g last.
    assign pick_ptr_s = (state_q == SHOW) ? gidx_q : ptr_q;

    lcd_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_i    (req),
        .urgent_i (urgent),
        .ptr_i    (pick_ptr_s),
        .valid_o  (pick_valid_s),
        .pick_o   (pick_oh_s),
        .idx_o    (pick_idx_s)
    );

    assign min_ok_s        = (cnt_q >= CNT_MIN);
    assign others_urgent_s = |(req & urgent & ~grant_q);
    assign release_s       = (cnt_q == CNT_LAST)
                           || (min_ok_s && !req[gidx_q])
                           || (min_ok_s && !urgent[gidx_q] && others_urgent_s);

    // Arbiter FSM: grant, hold, release and back-to-back handover.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q <= IDLE;
            grant_q <= {N_REQ{1'b0}};
            done_q  <= {N_REQ{1'b0}};
            gidx_q  <= {IW{1'b0}};
            ptr_q   <= IW'(N_REQ - 1);
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            row1_q  <= DEF_ROW1;
            row2_q  <= DEF_ROW2;
        end else begin
            done_q <= {N_REQ{1'b0}};
            case (state_q)
                IDLE: begin
                    if (pick_valid_s) begin
                        state_q <= SHOW;
                        grant_q <= pick_oh_s;
                        gidx_q  <= pick_idx_s;
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                        row1_q  <= row1_arr_s[pick_idx_s];
                        row2_q  <= row2_arr_s[pick_idx_s];
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                SHOW: begin
                    if (release_s) begin
                        done_q <= grant_q;
                        ptr_q  <= gidx_q;
                        cnt_q  <= {CW{1'b0}};
                        if (pick_valid_s) begin
                            grant_q <= pick_oh_s;
                            gidx_q  <= pick_idx_s;
                            row1_q  <= row1_arr_s[pick_idx_s];
                            row2_q  <= row2_arr_s[pick_idx_s];
                        end else begin
                            state_q <= IDLE;
                            grant_q <= {N_REQ{1'b0}};
                            busy_q  <= 1'b0;
                            row1_q  <= DEF_ROW1;
                            row2_q  <= DEF_ROW2;
                        end
                    end else begin
                        // Saturating count; the limit itself always releases.
                        cnt_q <= (cnt_q < CNT_LAST) ? cnt_q + 1'b1 : cnt_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= {N_REQ{1'b0}};
                    busy_q  <= 1'b0;
                    row1_q  <= DEF_ROW1;
                    row2_q  <= DEF_ROW2;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign row_1 = row1_q;
    assign row_2 = row2_q;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Scoreboard bench for lcd_msg_arbiter: a reference model predicts every
// cycle's outputs into a queue; a monitor pops and compares after each edge.
module tb_lcd_msg_arbiter;

    localparam int N    = 4;
    localparam int RW   = 160;
    localparam int HOLD = 16;
    localparam int MINC = 4;

    typedef struct {
        logic [N-1:0]  g;
        logic [N-1:0]  d;
        logic          b;
        logic [RW-1:0] r1;
        logic [RW-1:0] r2;
    } exp_t;

    logic            CLK = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    urgent = '0;
    logic [N*RW-1:0] req_row1 = '0;
    logic [N*RW-1:0] req_row2 = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [RW-1:0]   row_1;
    logic [RW-1:0]   row_2;

    logic [RW-1:0] spaces;
    exp_t          q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    // Reference model state: who is on screen, for how many cycles, last winner.
    int            m_cur  = -1;
    int            m_shown = 0;
    int            m_last = N - 1;
    logic [RW-1:0] m_r1;
    logic [RW-1:0] m_r2;

    lcd_msg_arbiter #(
        .N_REQ(N), .ROW_W(RW), .HOLD_CYCLES(HOLD), .MIN_CYCLES(MINC)
    ) dut (
        .CLK(CLK), ._RST(rst_n), .req(req), .urgent(urgent),
        .req_row1(req_row1), .req_row2(req_row2), .grant(grant), .done(done),
        .busy(busy), .row_1(row_1), .row_2(row_2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // First requester in rotated order after 'last', urgent ones preferred.
    function automatic int ref_pick(logic [N-1:0] r, logic [N-1:0] u, int last);
        logic [N-1:0] c;
        int idx;
        c = (|(r & u)) ? (r & u) : r;
        for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (c[idx] == 1'b1) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cur = -1; m_shown = 0; m_last = N - 1;
        m_r1 = spaces; m_r2 = spaces;
    endtask

    task automatic model_grant(input int p);
        m_cur = p; m_shown = 1;
        m_r1 = req_row1[p*RW +: RW];
        m_r2 = req_row2[p*RW +: RW];
    endtask

    // Predict the outputs seen after the coming edge from the inputs now applied.
    task automatic model_step();
        exp_t e;
        int p;
        bit rel, contender;
        e.d = '0;
        if (m_cur < 0) begin
            p = ref_pick(req, urgent, m_last);
            if (p >= 0) model_grant(p);
        end else begin
            contender = 1'b0;
            for (int j = 0; j < N; j++)
                if (j != m_cur && req[j] && urgent[j]) contender = 1'b1;
            rel = (m_shown == HOLD)
               || (m_shown >= MINC && !req[m_cur])
               || (m_shown >= MINC && !urgent[m_cur] && contender);
            if (rel) begin
                e.d[m_cur] = 1'b1;
                m_last = m_cur;
                p = ref_pick(req, urgent, m_last);
                if (p >= 0) model_grant(p);
                else begin
                    m_cur = -1; m_r1 = spaces; m_r2 = spaces;
                end
            end else begin
                m_shown++;
            end
        end
        e.g = '0;
        if (m_cur >= 0) e.g[m_cur] = 1'b1;
        e.b  = (m_cur >= 0);
        e.r1 = m_r1;
        e.r2 = m_r2;
        q.push_back(e);
    endtask

    task automatic scramble_rows();
        for (int w = 0; w < N*RW/32; w++) begin
            req_row1[w*32 +: 32] = $urandom();
            req_row2[w*32 +: 32] = $urandom();
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] u);
        @(negedge CLK); #1;
        req = r; urgent = u;
        if ($urandom_range(0, 3) == 0) scramble_rows();
        model_step();
    endtask

    task automatic steps(input int n, input logic [N-1:0] r, input logic [N-1:0] u);
        for (int i = 0; i < n; i++) step(r, u);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, RW'(grant), RW'(0));
        check({tag, "_done"},  RW'(done),  RW'(0));
        check({tag, "_busy"},  RW'(busy),  RW'(0));
        check({tag, "_row1"},  row_1, spaces);
        check({tag, "_row2"},  row_2, spaces);
    endtask

    // Monitor: compare DUT outputs against the next predicted entry.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("grant", RW'(grant), RW'(e.g));
            check("done",  RW'(done),  RW'(e.d));
            check("busy",  RW'(busy),  RW'(e.b));
            check("row_1", row_1, e.r1);
            check("row_2", row_2, e.r2);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        spaces = {20{8'h20}};
        model_reset();
        scramble_rows();
        repeat (3) @(negedge CLK);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        steps(3, 4'b0000, 4'b0000);

        // Single request held past the full hold, then dropped.
        steps(18, 4'b0010, 4'b0000);
        steps(6, 4'b0000, 4'b0000);

        // All requesting: round-robin with back-to-back handover.
        steps(4 * HOLD + 4, 4'b1111, 4'b0000);
        steps(6, 4'b0000, 4'b0000);

        // Early release: drop shortly after grant, then late in the hold.
        steps(2, 4'b0001, 4'b0000);
        steps(6, 4'b0000, 4'b0000);
        steps(10, 4'b0001, 4'b0000);
        steps(4, 4'b0000, 4'b0000);

        // Urgent preemption of a plain grant, then no preemption of an urgent one.
        steps(3, 4'b0001, 4'b0000);
        steps(20, 4'b0101, 4'b0100);
        steps(6, 4'b0000, 4'b0000);
        steps(3, 4'b0001, 4'b0001);
        steps(20, 4'b0101, 4'b0101);
        steps(6, 4'b0000, 4'b0000);

        // Asynchronous reset in the middle of a display.
        steps(8, 4'b0100, 4'b0000);
        @(negedge CLK); #1;
        req = '0; urgent = '0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        q.delete();
        repeat (2) @(negedge CLK);
        #1 rst_n = 1'b1;
        steps(20, 4'b1111, 4'b0000);

        // Randomized traffic with occasional request and urgency changes.
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0] r, u;
            r = req; u = urgent;
            if ($urandom_range(0, 7) == 0) r = N'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) u = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            step(r, u);
        end
        steps(4, 4'b0000, 4'b0000);

        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_msg_arbiter.md
# lcd_msg_arbiter

Time-shares the single 2x20 character LCD between several game modules (timer, puzzle modules, strike/defuse banners). Each requester presents two 160-bit ASCII rows and a request. The block grants one requester at a time and holds that requester's text on the LCD long enough to be read. It supports urgent preemption, and shows a default banner when nobody is requesting. Its row_1/row_2 outputs feed the row inputs of the LCD2002 character driver directly.

## Interface
- N_REQ, 4: number of requesters (2..8).
- ROW_W, 160: bits per row (20 chars x 8-bit ASCII).
- HOLD_CYCLES, 50_000_000: maximum display time per grant (1 s at 50 MHz).
- MIN_CYCLES, 5_000_000: minimum display time before early release or preemption (100 ms; exceeds one full LCD refresh of 4.2 M cycles).
- DEF_ROW1 / DEF_ROW2, 20 ASCII spaces each: idle banner.

Ports:
- CLK  in  1  clock.
- _RST  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  level request per requester; held until grant or withdrawn.
- urgent  in  N_REQ  qualifies req; only meaningful when the matching req bit is 1.
- req_row1  in  N_REQ*ROW_W  flattened row-1 text; requester i occupies [i*ROW_W +: ROW_W].
- req_row2  in  N_REQ*ROW_W  flattened row-2 text, same packing as req_row1.
- grant  out  N_REQ  one-hot or zero; the requester currently displayed.
- done  out  N_REQ  one-cycle pulse to the requester whose grant just ended.
- busy  out  1  high while in SHOW.
- row_1  out  ROW_W  text to the LCD driver, row 1.
- row_2  out  ROW_W  text to the LCD driver, row 2.

## Operation
- States: IDLE and SHOW.
- Reset values:
  - state IDLE; grant 0; done 0; busy 0.
  - row_1 = DEF_ROW1; row_2 = DEF_ROW2.
  - hold counter 0; last-granted pointer N_REQ-1, so requester 0 has first round-robin priority.
- Pick function, over the candidate set req:
  - If any urgent candidate exists, take the first urgent one in rotated order starting at pointer+1.
  - Otherwise take the first req in that order.
- IDLE:
  - If req != 0, the pick is granted at the next edge.
  - Row registers snapshot that requester's req_row1/req_row2 at the same edge.
  - Counter cleared; state goes to SHOW.
- SHOW:
  - Counter increments each cycle and saturates at HOLD_CYCLES-1.
  - Rows stay frozen; changes to req_row* of the granted requester are ignored until the next grant.
- Release condition (g = granted index), any of:
  - counter == HOLD_CYCLES-1;
  - counter >= MIN_CYCLES-1 and req[g] == 0 (early release);
  - counter >= MIN_CYCLES-1 and urgent[g] == 0 and some j != g has req[j] & urgent[j] (preemption).
- On release:
  - done[g] pulses for one cycle and the pointer is set to g.
  - If the remaining req is nonzero, the new pick is granted at the same edge: back-to-back, no idle gap, new snapshot, counter cleared. g itself remains eligible but ranks last.
  - Otherwise go to IDLE and load the default rows.
- Urgent never preempts another urgent grant; it also never preempts before MIN_CYCLES.
- Withdrawn request before MIN_CYCLES: the display holds until MIN_CYCLES-1, then releases.
- Asynchronous reset mid-SHOW: immediate return to reset values; no done pulse.

## Timing
- Grant latency from IDLE: req sampled high at edge k gives grant, busy and new rows valid after edge k+1 (1 cycle).
- Normal hold: grant is high for exactly HOLD_CYCLES cycles; done[g] is high in cycle HOLD_CYCLES+1 after grant.
- Back-to-back handover: grant switches directly from one-hot g to one-hot h in a single edge. done[g] and grant[h] are both high in the same cycle.
- grant and done are registered outputs, with no combinational path from req.
- Counter width: $clog2(HOLD_CYCLES). MIN_CYCLES must be <= HOLD_CYCLES, enforced with an elaboration-time check.

## Structure
- Package lcd_arb_pkg holds:
  - state enum {IDLE, SHOW};
  - ROW_W;
  - 20-char space banner constant;
  - helper function for the ASCII space fill.
- Sub-module lcd_rr_pick: combinational rotating-priority encoder.
  - Inputs: req, urgent, pointer.
  - Outputs: valid, one-hot pick, index.
  - Reused for both the IDLE and the release-handover picks.
- Text snapshot muxing and the counter live in the top module.

## Test plan
Benches use N_REQ=4, HOLD_CYCLES=16, MIN_CYCLES=4.
- Reset: after release, row_1/row_2 = 20 spaces; grant=0, busy=0 -> no activity with req=0.
- Single request: req=4'b0010 at edge k, held -> grant=0010 at k+1, row_1=req_row1[1]; grant held 16 cycles, then done=0010 for 1 cycle; if req has been dropped by then, defaults restored.
- Round-robin: req=4'b1111 held constantly -> grants 0001, 0010, 0100, 1000, 0001, each 16 cycles long, with no gap between grants.
- Early release: grant to 0 then req[0] dropped at counter=1 -> release at counter=3 (4 cycles total); a drop at counter=9 -> release on the next edge.
- Urgent preemption: req0 shown, and req[2] with urgent[2] rises at counter=2 -> handover to 0100 at counter=3 with done[0]. If req0 is itself urgent -> no preemption; req0 runs its full 16 cycles.
- Reset mid-SHOW at counter=7 -> outputs return to reset values immediately and done stays 0; after release, re-arbitration starts from requester 0.
